// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator call scheduler.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        DOOR       = 2'b01,
        SERVE_UP   = 2'b10,
        SERVE_DOWN = 2'b11
    } state_e;

    localparam int DEF_NUM_FLOORS = 5;
    localparam int DEF_FLOOR_W    = 4;

endpackage

// File: rtl/elevator_call_finder.sv
// Combinational search for the nearest pending call above and below the current floor.
module elevator_call_finder
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = DEF_FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]    current_floor_i,
    output logic                  any_above_o,
    output logic                  any_below_o,
    output logic [FLOOR_W-1:0]    next_above_o,
    output logic [FLOOR_W-1:0]    next_below_o
);

    // Above scans downward so the last hit is the lowest; below scans upward for the highest.
    always_comb begin
        any_above_o  = 1'b0;
        next_above_o = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_i[i] && (int'(current_floor_i) < i)) begin
                any_above_o  = 1'b1;
                next_above_o = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        any_below_o  = 1'b0;
        next_below_o = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_i[i] && (int'(current_floor_i) > i)) begin
                any_below_o  = 1'b1;
                next_below_o = FLOOR_W'(i);
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN-order call scheduler with door dwell timer.
// Optional IDLE_HOME_EN: park at HOME_FLOOR after HOME_TIMEOUT idle cycles with no calls.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
    parameter int FLOOR_W     = DEF_FLOOR_W,
    parameter int DOOR_CYCLES = 1000
`ifdef IDLE_HOME_EN
   ,parameter int HOME_FLOOR   = 1,
    parameter int HOME_TIMEOUT = 5000
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_FLOORS-1:0] call_req_i,
    input  logic [FLOOR_W-1:0]    current_floor_i,
    input  logic                  elevator_idle_i,
    output logic [FLOOR_W-1:0]    target_floor_o,
    output logic [NUM_FLOORS-1:0] pending_o,
    output logic                  door_open_o,
    output logic                  dir_up_o
);

    localparam int              DW         = $clog2(DOOR_CYCLES + 1);
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DOOR_CYCLES - 1);

    state_e                  state_q, state_d, scan_state;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d, pend_set, cur_mask, home_call;
    logic [FLOOR_W-1:0]      target_q, target_d, next_above, next_below;
    logic [DW-1:0]           dwell_q, dwell_d;
    logic                    door_q, door_d, dir_q, dir_d, scan_dir;
    logic                    cur_valid, cur_pend, cur_call, enter_door, any_above, any_below;

    assign cur_valid = int'(current_floor_i) < NUM_FLOORS;

    always_comb begin
        for (int i = 0; i < NUM_FLOORS; i++) begin
            cur_mask[i] = cur_valid && (int'(current_floor_i) == i);
        end
    end

`ifdef IDLE_HOME_EN
    localparam int HW = $clog2(HOME_TIMEOUT + 1);
    logic [HW-1:0] home_q, home_d;

    always_comb begin
        home_d    = home_q;
        home_call = '0;
        if ((state_q != IDLE) || (|call_req_i) || (|pending_q)) begin
            home_d = '0;
        end else if (home_q != HW'(HOME_TIMEOUT)) begin
            home_d = home_q + 1'b1;
        end
        if ((state_q == IDLE) && (pending_q == '0) && (home_q == HW'(HOME_TIMEOUT))
            && cur_valid && (int'(current_floor_i) != HOME_FLOOR)) begin
            home_call[HOME_FLOOR] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) home_q <= '0;
        else       home_q <= home_d;
    end
`else
    assign home_call = '0;
`endif

    // A call at the open door is absorbed by the dwell restart instead of being latched.
    assign pend_set = pending_q | home_call
                    | (call_req_i & ~((state_q == DOOR) ? cur_mask : '0));
    assign cur_pend = |(pend_set & cur_mask);
    assign cur_call = |(call_req_i & cur_mask);

    elevator_call_finder #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_finder (
        .pending_i       (pend_set),
        .current_floor_i (current_floor_i),
        .any_above_o     (any_above),
        .any_below_o     (any_below),
        .next_above_o    (next_above),
        .next_below_o    (next_below)
    );

    always_comb begin
        scan_state = IDLE;
        scan_dir   = dir_q;
        if (!cur_valid) begin
            scan_state = IDLE;
        end else if (cur_pend && elevator_idle_i) begin
            scan_state = DOOR;
        end else if (dir_q ? any_above : any_below) begin
            scan_state = dir_q ? SERVE_UP : SERVE_DOWN;
        end else if (dir_q ? any_below : any_above) begin
            scan_state = dir_q ? SERVE_DOWN : SERVE_UP;
            scan_dir   = !dir_q;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        dwell_d = dwell_q;
        case (state_q)
            IDLE: begin
                state_d = scan_state;
                dir_d   = scan_dir;
            end
            SERVE_UP, SERVE_DOWN: begin
                if (!cur_valid) begin
                    state_d = state_q;
                end else if ((current_floor_i == target_q) && elevator_idle_i) begin
                    state_d = DOOR;
                end else if (!((state_q == SERVE_UP) ? any_above : any_below)) begin
                    state_d = scan_state;
                    dir_d   = scan_dir;
                end
            end
            DOOR: begin
                if (cur_call) begin
                    dwell_d = '0;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    state_d = scan_state;
                    dir_d   = scan_dir;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        enter_door = (state_d == DOOR) && (state_q != DOOR);
        if (enter_door) dwell_d = '0;
        pending_d = pend_set & ~(enter_door ? cur_mask : '0);
        door_d    = (state_d == DOOR);

        target_d = target_q;
        if (cur_valid) begin
            case (state_d)
                SERVE_UP:   if (any_above) target_d = next_above;
                SERVE_DOWN: if (any_below) target_d = next_below;
                default:    target_d = current_floor_i;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
            target_q  <= '0;
            dwell_q   <= '0;
            door_q    <= 1'b0;
            dir_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            target_q  <= target_d;
            dwell_q   <= dwell_d;
            door_q    <= door_d;
            dir_q     <= dir_d;
        end
    end

    assign target_floor_o = target_q;
    assign pending_o      = pending_q;
    assign door_open_o    = door_q;
    assign dir_up_o       = dir_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scoreboard bench for elevator_call_scheduler; home-parking scenario only with IDLE_HOME_EN.
module tb_elevator_call_scheduler;

    localparam int NF = 5;
    localparam int FW = 4;
    localparam int DC = 6;
`ifdef IDLE_HOME_EN
    localparam int HF = 1;
    localparam int HT = 20;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NF-1:0] call_req;
    logic [FW-1:0] cur;
    logic          idle;
    logic [FW-1:0] target;
    logic [NF-1:0] pending;
    logic          door;
    logic          dir_up;

    int n_run  = 0;
    int n_fail = 0;
    int exp_q[$];
    int e;

    always #5 clk = ~clk;

    elevator_call_scheduler #(
        .NUM_FLOORS   (NF),
        .FLOOR_W      (FW),
        .DOOR_CYCLES  (DC)
`ifdef IDLE_HOME_EN
       ,.HOME_FLOOR   (HF),
        .HOME_TIMEOUT (HT)
`endif
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .call_req_i      (call_req),
        .current_floor_i (cur),
        .elevator_idle_i (idle),
        .target_floor_o  (target),
        .pending_o       (pending),
        .door_open_o     (door),
        .dir_up_o        (dir_up)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts samples with the door open, starting at the current one; bounded.
    task automatic run_door(output int len);
        len = 0;
        while (door === 1'b1 && len < 200) begin
            len++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; call_req = '0; cur = '0; idle = 1'b1;
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
        step(); step();
        e = exp_q.pop_front(); n_run++;
        if (pending !== NF'(e)) begin n_fail++; $display("FAIL reset_pending got %b want %b", pending, NF'(e)); end
        e = exp_q.pop_front(); n_run++;
        if (target !== FW'(e)) begin n_fail++; $display("FAIL reset_target got %0d want %0d", target, e); end
        e = exp_q.pop_front(); n_run++;
        if (door !== 1'(e)) begin n_fail++; $display("FAIL reset_door got %b want %0d", door, e); end
        e = exp_q.pop_front(); n_run++;
        if (dir_up !== 1'(e)) begin n_fail++; $display("FAIL reset_dir got %b want %0d", dir_up, e); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_serve_door();
        int len;
        call_req = 5'b01000;
        exp_q.push_back(8); exp_q.push_back(3);
        step();
        call_req = '0;
        e = exp_q.pop_front(); n_run++;
        if (pending !== NF'(e)) begin n_fail++; $display("FAIL serve_pending got %b want %b", pending, NF'(e)); end
        e = exp_q.pop_front(); n_run++;
        if (target !== FW'(e)) begin n_fail++; $display("FAIL serve_target got %0d want %0d", target, e); end
        idle = 1'b0;
        step(); step();
        cur = 4'd3; idle = 1'b1;
        exp_q.push_back(1); exp_q.push_back(0);
        step();
        e = exp_q.pop_front(); n_run++;
        if (door !== 1'(e)) begin n_fail++; $display("FAIL serve_door_open got %b want %0d", door, e); end
        e = exp_q.pop_front(); n_run++;
        if (pending !== NF'(e)) begin n_fail++; $display("FAIL serve_pending_clear got %b want %b", pending, NF'(e)); end
        exp_q.push_back(DC);
        run_door(len);
        e = exp_q.pop_front(); n_run++;
        if (len !== e) begin n_fail++; $display("FAIL serve_dwell_len got %0d want %0d", len, e); end
    endtask

    task automatic test_retarget();
        int len;
        cur = 4'd1; idle = 1'b1;
        step();
        call_req = 5'b10000;
        exp_q.push_back(4);
        step();
        call_req = '0;
        e = exp_q.pop_front(); n_run++;
        if (target !== FW'(e)) begin n_fail++; $display("FAIL retarget_first got %0d want %0d", target, e); end
        idle = 1'b0;
        step();
        call_req = 5'b00100;
        exp_q.push_back(2);
        step();
        call_req = '0;
        e = exp_q.pop_front(); n_run++;
        if (target !== FW'(e)) begin n_fail++; $display("FAIL retarget_nearer got %0d want %0d", target, e); end
        cur = 4'd2; idle = 1'b1;
        step();
        run_door(len);
        exp_q.push_back(4);
        e = exp_q.pop_front(); n_run++;
        if (target !== FW'(e)) begin n_fail++; $display("FAIL retarget_resume got %0d want %0d", target, e); end
        cur = 4'd4;
        step();
        run_door(len);
    endtask

    task automatic test_tie();
        int len;
        cur = 4'd2; idle = 1'b1;
        step();
        call_req = 5'b10001;
        exp_q.push_back(4); exp_q.push_back(1);
        step();
        call_req = '0;
        e = exp_q.pop_front(); n_run++;
        if (target !== FW'(e)) begin n_fail++; $display("FAIL tie_target got %0d want %0d", target, e); end
        e = exp_q.pop_front(); n_run++;
        if (dir_up !== 1'(e)) begin n_fail++; $display("FAIL tie_dir got %b want %0d", dir_up, e); end
        idle = 1'b0;
        step();
        cur = 4'd4; idle = 1'b1;
        step();
        run_door(len);
        exp_q.push_back(0); exp_q.push_back(0);
        e = exp_q.pop_front(); n_run++;
        if (target !== FW'(e)) begin n_fail++; $display("FAIL reverse_target got %0d want %0d", target, e); end
        e = exp_q.pop_front(); n_run++;
        if (dir_up !== 1'(e)) begin n_fail++; $display("FAIL reverse_dir got %b want %0d", dir_up, e); end
        cur = 4'd0;
        step();
        run_door(len);
    endtask

    task automatic test_door_restart();
        int len;
        call_req = 5'b00100;
        step();
        call_req = '0;
        cur = 4'd2; idle = 1'b1;
        step();
        step(); step(); step();
        call_req = 5'b00100;
        exp_q.push_back(0); exp_q.push_back(DC);
        step();
        call_req = '0;
        e = exp_q.pop_front(); n_run++;
        if (pending !== NF'(e)) begin n_fail++; $display("FAIL restart_pending got %b want %b", pending, NF'(e)); end
        run_door(len);
        e = exp_q.pop_front(); n_run++;
        if (len !== e) begin n_fail++; $display("FAIL restart_dwell_len got %0d want %0d", len, e); end
    endtask

    task automatic test_out_of_range();
        int len;
        cur = 4'd7; idle = 1'b1;
        step();
        call_req = 5'b01000;
        exp_q.push_back(2); exp_q.push_back(8); exp_q.push_back(0);
        step();
        call_req = '0;
        e = exp_q.pop_front(); n_run++;
        if (target !== FW'(e)) begin n_fail++; $display("FAIL oor_target_hold got %0d want %0d", target, e); end
        e = exp_q.pop_front(); n_run++;
        if (pending !== NF'(e)) begin n_fail++; $display("FAIL oor_pending got %b want %b", pending, NF'(e)); end
        e = exp_q.pop_front(); n_run++;
        if (door !== 1'(e)) begin n_fail++; $display("FAIL oor_door got %b want %0d", door, e); end
        cur = 4'd3;
        exp_q.push_back(1);
        step();
        e = exp_q.pop_front(); n_run++;
        if (door !== 1'(e)) begin n_fail++; $display("FAIL oor_recover_door got %b want %0d", door, e); end
        run_door(len);
    endtask

    task automatic test_reset_mid_dwell();
        cur = 4'd2; idle = 1'b1;
        step();
        call_req = 5'b00100;
        exp_q.push_back(1);
        step();
        call_req = '0;
        e = exp_q.pop_front(); n_run++;
        if (door !== 1'(e)) begin n_fail++; $display("FAIL middwell_door got %b want %0d", door, e); end
        step(); step();
        rst = 1'b1;
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
        step();
        e = exp_q.pop_front(); n_run++;
        if (door !== 1'(e)) begin n_fail++; $display("FAIL middwell_rst_door got %b want %0d", door, e); end
        e = exp_q.pop_front(); n_run++;
        if (target !== FW'(e)) begin n_fail++; $display("FAIL middwell_rst_target got %0d want %0d", target, e); end
        e = exp_q.pop_front(); n_run++;
        if (dir_up !== 1'(e)) begin n_fail++; $display("FAIL middwell_rst_dir got %b want %0d", dir_up, e); end
        rst = 1'b0;
        step();
    endtask

`ifdef IDLE_HOME_EN
    task automatic test_home();
        int cnt;
        cur = 4'd3; idle = 1'b1;
        exp_q.push_back(1); exp_q.push_back(1);
        cnt = 0;
        while (pending[HF] !== 1'b1 && cnt < HT + 20) begin
            step();
            cnt++;
        end
        e = exp_q.pop_front(); n_run++;
        if (pending[HF] !== 1'(e)) begin n_fail++; $display("FAIL home_pending got %b want %0d", pending[HF], e); end
        e = exp_q.pop_front(); n_run++;
        if (target !== FW'(e)) begin n_fail++; $display("FAIL home_target got %0d want %0d", target, e); end
    endtask
`endif

    initial begin
        test_reset();
        test_serve_door();
        test_retarget();
        test_tie();
        test_door_restart();
        test_out_of_range();
        test_reset_mid_dwell();
`ifdef IDLE_HOME_EN
        test_home();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d comparisons", n_run);
        $fatal(1);
    end

endmodule
